sync_fifo_ft: RTL and testbench

Parametrised single-clock FIFO succeeding our fixed-size synchronous FIFO. Adds configurable width and depth (any depth ≥ 2, not only powers of two), a selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Sits between a producer and consumer in the same clock domain and is the DUT for the next generation of the FIFO UVM environment.

---
 rtl/fifo_rtl_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 25 ++
 rtl/sync_fifo_ft.sv | 122 ++++++++++++
 tb/tb_sync_fifo_ft.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rtl_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO family.
package fifo_rtl_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PW         = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [PW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ft.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_ft
    import fifo_rtl_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 2,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic [fifo_count_width(DEPTH)-1:0]   count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int CW = fifo_count_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [PW-1:0]         w_wr_ptr_inc;
    logic [PW-1:0]         w_rd_ptr_inc;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Flags come only from the registered count, so no input reaches them combinationally.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PW         (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                end else if (flush) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= w_mem_rdata;
                end
            end

            assign rd_data = r_rd_data;
        end else begin : g_fwft
            // Head word is presented directly; meaningless while empty.
            assign rd_data = w_mem_rdata;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ft.sv
// Scoreboard bench for sync_fifo_ft: a DEPTH=5 standard-mode instance (AF=4, AE=1)
// and a DEPTH=16 first-word-fall-through instance.
module tb_sync_fifo_ft;
    import fifo_rtl_pkg::*;

    localparam int AF_A = 4;
    localparam int AE_A = 1;
    localparam int DEPTH_A = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH 5, standard read mode
    logic       a_flush = 0, a_wr_en = 0, a_rd_en = 0;
    logic [7:0] a_wr_data = '0, a_rd_data;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;

    // Instance B: DEPTH 16, FWFT read mode
    logic       b_flush = 0, b_wr_en = 0, b_rd_en = 0;
    logic [7:0] b_wr_data = '0, b_rd_data;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0] b_count;

    sync_fifo_ft #(.DATA_WIDTH(8), .DEPTH(DEPTH_A), .AF_THRESH(AF_A), .AE_THRESH(AE_A), .MODE(FIFO_STD)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf));

    sync_fifo_ft #(.DATA_WIDTH(8), .DEPTH(16), .MODE(FIFO_FWFT)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf));

    int n_vec = 0;
    int n_err = 0;

    // Reference models
    logic [7:0] a_q[$];
    logic [7:0] a_exp_rd = '0;
    bit         a_exp_ovf = 0, a_exp_unf = 0;
    logic [7:0] b_q[$];
    bit         b_exp_unf = 0;

    task automatic step_a(input bit wr, input bit rd, input logic [7:0] d, input bit fl);
        bit wacc, racc;
        a_wr_en = wr; a_rd_en = rd; a_wr_data = d; a_flush = fl;
        @(posedge clk); #1;
        if (fl) begin
            a_q.delete(); a_exp_rd = '0; a_exp_ovf = 0; a_exp_unf = 0;
        end else begin
            wacc = wr && (a_q.size() < DEPTH_A);
            racc = rd && (a_q.size() > 0);
            if (wr && !wacc) a_exp_ovf = 1;
            if (rd && !racc) a_exp_unf = 1;
            if (racc) a_exp_rd = a_q.pop_front();
            if (wacc) a_q.push_back(d);
        end
        a_wr_en = 0; a_rd_en = 0; a_flush = 0;
        $display("A wr=%0b rd=%0b fl=%0b din=%02h -> count=%0d rd_data=%02h ovf=%0b unf=%0b",
                 wr, rd, fl, d, a_count, a_rd_data, a_ovf, a_unf);
    endtask

    task automatic step_b(input bit wr, input bit rd, input logic [7:0] d);
        bit wacc, racc;
        b_wr_en = wr; b_rd_en = rd; b_wr_data = d;
        @(posedge clk); #1;
        wacc = wr && (b_q.size() < 16);
        racc = rd && (b_q.size() > 0);
        if (rd && !racc) b_exp_unf = 1;
        if (racc) void'(b_q.pop_front());
        if (wacc) b_q.push_back(d);
        b_wr_en = 0; b_rd_en = 0;
        $display("B wr=%0b rd=%0b din=%02h -> count=%0d rd_data=%02h empty=%0b unf=%0b",
                 wr, rd, d, b_count, b_rd_data, b_empty, b_unf);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_rd_data} !== {3'd0, 6'b101000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_a: got cnt=%0d e=%0b f=%0b ae=%0b af=%0b ov=%0b un=%0b rd=%02h, want 0 1 0 1 0 0 0 00",
                     a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_rd_data);
        end
        n_vec++;
        if ({b_count, b_empty, b_full, b_ae, b_af, b_ovf, b_unf} !== {5'd0, 6'b101000}) begin
            n_err++;
            $display("FAIL reset_b: got cnt=%0d e=%0b f=%0b ae=%0b af=%0b ov=%0b un=%0b, want 0 1 0 1 0 0 0",
                     b_count, b_empty, b_full, b_ae, b_af, b_ovf, b_unf);
        end
        #3 rst_n = 1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            step_a(1, 0, 8'h11 + 8'(i), 0);
            n_vec++;
            if (a_count !== 3'(i + 1) || a_ae !== ((i + 1) <= AE_A) || a_af !== ((i + 1) >= AF_A)
                || a_empty !== 1'b0 || a_full !== (i == 4)) begin
                n_err++;
                $display("FAIL fill[%0d]: got cnt=%0d ae=%0b af=%0b e=%0b f=%0b, want cnt=%0d ae=%0b af=%0b e=0 f=%0b",
                         i, a_count, a_ae, a_af, a_empty, a_full, i + 1, (i + 1) <= AE_A, (i + 1) >= AF_A, i == 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step_a(0, 1, 8'h00, 0);
            n_vec++;
            if (a_rd_data !== a_exp_rd || a_exp_rd !== 8'h11 + 8'(i) || a_count !== 3'(a_q.size())) begin
                n_err++;
                $display("FAIL drain[%0d]: got rd=%02h cnt=%0d, want rd=%02h cnt=%0d",
                         i, a_rd_data, a_count, 8'h11 + 8'(i), a_q.size());
            end
        end
        n_vec++;
        if (a_empty !== 1'b1 || a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL drained_empty: got e=%0b un=%0b, want e=1 un=0", a_empty, a_unf);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) step_a(1, 0, 8'h30 + 8'(i), 0);
        step_a(0, 0, 8'h00, 0);
        n_vec++;
        if (a_ovf !== 1'b1 || a_count !== 3'd5 || a_full !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: got ov=%0b cnt=%0d f=%0b, want ov=1 cnt=5 f=1", a_ovf, a_count, a_full);
        end
        // Full with simultaneous read and write: only the read is taken
        step_a(1, 1, 8'hAA, 0);
        n_vec++;
        if (a_rd_data !== a_exp_rd || a_exp_rd !== 8'h30 || a_count !== 3'd4 || a_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL full_wr_rd: got rd=%02h cnt=%0d ov=%0b, want rd=30 cnt=4 ov=1", a_rd_data, a_count, a_ovf);
        end
        step_a(1, 0, 8'h55, 1);
        n_vec++;
        if (a_count !== 3'd0 || a_ovf !== 1'b0 || a_empty !== 1'b1 || a_rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL flush: got cnt=%0d ov=%0b e=%0b rd=%02h, want cnt=0 ov=0 e=1 rd=00",
                     a_count, a_ovf, a_empty, a_rd_data);
        end
    endtask

    task automatic test_wrap();
        int max_cnt = 0;
        int bad = 0;
        for (int i = 0; i < 12; i++) begin
            step_a(1, 0, 8'h20 + 8'(i), 0);
            if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
            step_a(0, 1, 8'h00, 0);
            n_vec++;
            if (a_rd_data !== a_exp_rd || a_exp_rd !== 8'h20 + 8'(i)) begin
                n_err++;
                $display("FAIL wrap[%0d]: got rd=%02h, want %02h", i, a_rd_data, 8'h20 + 8'(i));
            end
        end
        n_vec++;
        if (max_cnt != 1 || a_empty !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_count: got max=%0d e=%0b, want max=1 e=1", max_cnt, a_empty);
        end
    endtask

    task automatic test_empty_wr_rd();
        step_a(1, 1, 8'h77, 0);
        n_vec++;
        if (a_count !== 3'd1 || a_unf !== 1'b1 || a_ovf !== 1'b0 || a_unf !== logic'(a_exp_unf)) begin
            n_err++;
            $display("FAIL empty_wr_rd: got cnt=%0d un=%0b ov=%0b, want cnt=1 un=1 ov=0", a_count, a_unf, a_ovf);
        end
        step_a(0, 1, 8'h00, 0);
        n_vec++;
        if (a_rd_data !== 8'h77 || a_rd_data !== a_exp_rd) begin
            n_err++;
            $display("FAIL empty_wr_rd_data: got rd=%02h, want 77", a_rd_data);
        end
        step_a(0, 0, 8'h00, 1);
        n_vec++;
        if (a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL flush_unf: got un=%0b, want 0", a_unf);
        end
    endtask

    task automatic test_fwft();
        step_b(1, 0, 8'h5A);
        n_vec++;
        if (b_empty !== 1'b0 || b_rd_data !== 8'h5A || b_rd_data !== b_q[0]) begin
            n_err++;
            $display("FAIL fwft_first: got e=%0b rd=%02h, want e=0 rd=5a", b_empty, b_rd_data);
        end
        step_b(1, 0, 8'h5B);
        step_b(1, 0, 8'h5C);
        n_vec++;
        if (b_rd_data !== 8'h5A || b_count !== 5'd3) begin
            n_err++;
            $display("FAIL fwft_hold: got rd=%02h cnt=%0d, want rd=5a cnt=3", b_rd_data, b_count);
        end
        for (int i = 0; i < 3; i++) begin
            step_b(0, 1, 8'h00);
            n_vec++;
            if (b_count !== 5'(b_q.size()) || b_empty !== (b_q.size() == 0)
                || (b_q.size() > 0 && b_rd_data !== b_q[0])) begin
                n_err++;
                $display("FAIL fwft_pop[%0d]: got rd=%02h cnt=%0d e=%0b, want cnt=%0d", i, b_rd_data, b_count, b_empty, b_q.size());
            end
        end
        step_b(0, 1, 8'h00);
        n_vec++;
        if (b_unf !== 1'b1 || b_unf !== logic'(b_exp_unf) || b_count !== 5'd0 || b_empty !== 1'b1) begin
            n_err++;
            $display("FAIL fwft_underflow: got un=%0b cnt=%0d e=%0b, want un=1 cnt=0 e=1", b_unf, b_count, b_empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step_a(1, 0, 8'h40 + 8'(i), 0);
        step_a(0, 1, 8'h00, 0);
        n_vec++;
        if (a_ovf !== 1'b1 || a_rd_data !== 8'h40 || a_count !== 3'd4 || a_af !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got ov=%0b rd=%02h cnt=%0d af=%0b, want ov=1 rd=40 cnt=4 af=1",
                     a_ovf, a_rd_data, a_count, a_af);
        end
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_rd_data} !== {3'd0, 6'b101000, 8'h00}
            || b_unf !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got cnt=%0d e=%0b f=%0b ae=%0b af=%0b ov=%0b un=%0b rd=%02h b_un=%0b, want 0 1 0 1 0 0 0 00 0",
                     a_count, a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_rd_data, b_unf);
        end
        a_q.delete(); a_exp_rd = '0; a_exp_ovf = 0; a_exp_unf = 0;
        b_q.delete(); b_exp_unf = 0;
        @(negedge clk);
        rst_n = 1;
        step_a(1, 0, 8'h99, 0);
        n_vec++;
        if (a_count !== 3'd1 || a_empty !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_write: got cnt=%0d e=%0b, want cnt=1 e=0", a_count, a_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_empty_wr_rd();
        test_fwft();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
